// File: rtl/eq_pkg.sv
// Shared types for the stereo equalizer: queue sizing defaults, the queue
// sequencer state encoding and the sample/coefficient types used by the FIR stages.
package eq_pkg;

   localparam int DEPTH_DEF  = 1024;
   localparam int WINDOW_DEF = 1021;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } sq_state_t;

   typedef logic signed [15:0] sample_t;
   typedef logic signed [15:0] coeff_t;
   typedef logic signed [31:0] acc_t;

   typedef struct packed {
      sample_t lft;
      sample_t rght;
   } stereo_t;

endpackage

// File: rtl/dualPort1024x32.sv
// Simple dual-port sample RAM: synchronous write, registered synchronous read.
// Left channel lives in [31:16], right channel in [15:0].
module dualPort1024x32 #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the read register is reset so replay outputs read zero until the first readout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/stereo_sample_queue.sv
// Circular stereo sample queue that replays the most recent WINDOW samples,
// oldest first, to the FIR stages after every new sample once full.
//
// state | meaning
// IDLE  | waiting for a write that finds the queue full (or a pending readout)
// READ  | issuing WINDOW consecutive read addresses, one per cycle
// DRAIN | last read data on the outputs; restart at once if a write is pending
module stereo_sample_queue
   import eq_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int WINDOW = WINDOW_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wrt_smpl,
   input  logic signed [15:0] lft_smpl,
   input  logic signed [15:0] rght_smpl,
   output logic signed [15:0] lft_out,
   output logic signed [15:0] rght_out,
   output logic               sequencing
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WINDOW + 1);
   localparam logic [CW-1:0] WIN_C  = CW'(WINDOW);
   localparam logic [CW-1:0] LAST_C = CW'(WINDOW - 1);
   localparam logic [AW-1:0] TOP_C  = AW'(DEPTH - 1);

   sq_state_t     state;
   logic [AW-1:0] new_ptr;
   logic [AW-1:0] old_ptr;
   logic [AW-1:0] rd_addr;
   logic [CW-1:0] count;
   logic [CW-1:0] rd_left;
   logic          pending;
   logic          fills_now;
   logic [31:0]   rd_word;
   stereo_t       wr_word;

   function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
      return (p == TOP_C) ? '0 : p + 1'b1;
   endfunction

   assign wr_word   = {lft_smpl, rght_smpl};
   assign fills_now = wrt_smpl && (count >= LAST_C);

   dualPort1024x32 #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wrt_smpl),
      .waddr (new_ptr),
      .wdata (wr_word),
      .re    (state == READ),
      .raddr (rd_addr),
      .rdata (rd_word)
   );

   assign lft_out  = rd_word[31:16];
   assign rght_out = rd_word[15:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         new_ptr    <= '0;
         old_ptr    <= '0;
         rd_addr    <= '0;
         count      <= '0;
         rd_left    <= '0;
         pending    <= 1'b0;
         sequencing <= 1'b0;
      end else begin
         if (wrt_smpl) begin
            new_ptr <= inc_ptr(new_ptr);
            if (count != WIN_C) count <= count + 1'b1;
         end
         // Read data lags the address by one cycle, so valid follows READ by one.
         sequencing <= (state == READ);
         case (state)
            IDLE: begin
               if (pending || fills_now) begin
                  state   <= READ;
                  rd_addr <= old_ptr;
                  rd_left <= LAST_C;
                  pending <= 1'b0;
               end
            end
            READ: begin
               if (wrt_smpl) pending <= 1'b1;
               rd_addr <= inc_ptr(rd_addr);
               rd_left <= rd_left - 1'b1;
               if (rd_left == '0) begin
                  state   <= DRAIN;
                  old_ptr <= inc_ptr(old_ptr);
               end
            end
            DRAIN: begin
               // old_ptr already slid on the last READ cycle.
               if (pending || wrt_smpl) begin
                  state   <= READ;
                  rd_addr <= old_ptr;
                  rd_left <= LAST_C;
                  pending <= 1'b0;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stereo_sample_queue.sv
// Scoreboard bench: readout k after reset must replay samples k..k+WINDOW-1
// in write order; a negedge monitor pops and compares every valid output.
module tb_stereo_sample_queue;

   localparam int WINDOW = 1021;

   logic               clk;
   logic               rst_n;
   logic               wrt_smpl;
   logic signed [15:0] lft_smpl;
   logic signed [15:0] rght_smpl;
   logic signed [15:0] lft_out;
   logic signed [15:0] rght_out;
   logic               sequencing;

   stereo_sample_queue dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrt_smpl   (wrt_smpl),
      .lft_smpl   (lft_smpl),
      .rght_smpl  (rght_smpl),
      .lft_out    (lft_out),
      .rght_out   (rght_out),
      .sequencing (sequencing)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] hist [$];
   logic [31:0] exp_q [$];
   int n_ro;
   int n_cmp;
   int n_err;
   int n_rise;
   int run_len;
   int low_len;
   int last_gap;

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic write_sample(input logic [15:0] l);
      logic [15:0] r;
      r = 16'($urandom);
      lft_smpl  = l;
      rght_smpl = r;
      wrt_smpl  = 1'b1;
      @(negedge clk);
      wrt_smpl  = 1'b0;
      hist.push_back({l, r});
   endtask

   task automatic push_window();
      for (int i = 0; i < WINDOW; i++) exp_q.push_back(hist[n_ro + i]);
      n_ro++;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || sequencing) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (t >= 3000) begin
         n_err++;
         $display("FAIL wait_done timeout got %0d pending want 0", exp_q.size());
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst_n) begin
         run_len = 0;
         low_len = 0;
      end else if (sequencing) begin
         if (run_len == 0) begin
            n_rise++;
            last_gap = low_len;
         end
         run_len++;
         low_len = 0;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL replay_unexpected got %h want none", {lft_out, rght_out});
         end else begin
            e = exp_q.pop_front();
            if ({lft_out, rght_out} !== e) begin
               n_err++;
               $display("FAIL replay_data got %h want %h", {lft_out, rght_out}, e);
            end
         end
      end else begin
         if (run_len != 0) begin
            n_cmp++;
            if (run_len != WINDOW) begin
               n_err++;
               $display("FAIL burst_len got %0d want %0d", run_len, WINDOW);
            end
         end
         run_len = 0;
         low_len++;
      end
   end

   initial begin
      int r0;
      n_ro = 0; n_cmp = 0; n_err = 0; n_rise = 0;
      run_len = 0; low_len = 0; last_gap = 0;
      rst_n = 1'b0; wrt_smpl = 1'b0; lft_smpl = '0; rght_smpl = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_seq", int'(sequencing), 0);
      check("reset_lft", int'(lft_out), 0);
      check("reset_rght", int'(rght_out), 0);

      for (int n = 1; n <= 1020; n++) begin
         write_sample(16'(n));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      check("no_seq_before_full", n_rise, 0);
      check("lft_zero_before_full", int'(lft_out), 0);

      write_sample(16'd1021);
      push_window();
      @(negedge clk);
      check("seq_latency", int'(sequencing), 1);
      wait_done();
      check("first_readouts", n_rise, 1);
      check("hold_after_first", int'(lft_out), 1021);

      for (int n = 1022; n <= 1030; n++) begin
         write_sample(16'(n));
         push_window();
         repeat ($urandom_range(0, 2)) @(negedge clk);
         wait_done();
      end
      check("readouts_to_1030", n_rise, 10);
      check("hold_after_wrap", int'(lft_out), 1030);

      r0 = n_rise;
      write_sample(16'd1031);
      push_window();
      repeat (100 + $urandom_range(0, 50)) @(negedge clk);
      write_sample(16'd1032);
      push_window();
      repeat (100 + $urandom_range(0, 50)) @(negedge clk);
      write_sample(16'd1033);
      wait_done();
      check("pending_collapse", n_rise - r0, 2);
      check("pending_back_to_back_gap", last_gap, 1);
      check("hold_after_pending", int'(lft_out), 1032);

      write_sample(16'd1034);
      push_window();
      repeat (300) @(negedge clk);
      check("mid_read_seq", int'(sequencing), 1);
      rst_n = 1'b0;
      #1;
      check("abort_seq", int'(sequencing), 0);
      check("abort_lft", int'(lft_out), 0);
      check("abort_rght", int'(rght_out), 0);
      exp_q.delete();
      hist.delete();
      n_ro = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      r0 = n_rise;
      for (int n = 1; n <= 1020; n++) begin
         write_sample(16'(2000 + n));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      check("no_seq_after_reset_refill", n_rise - r0, 0);
      check("lft_zero_after_reset", int'(lft_out), 0);
      write_sample(16'd3021);
      push_window();
      wait_done();
      check("readout_after_refill", n_rise - r0, 1);
      check("hold_after_refill", int'(lft_out), 3021);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/stereo_sample_queue.md
STEREO_SAMPLE_QUEUE -- requirements
Module: stereo_sample_queue

Interface
REQ-001 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-002 Parameter DEPTH SHALL default to 1024 and set the number of queue entries.
REQ-003 Parameter WINDOW SHALL default to 1021 and set the number of samples replayed per readout.
REQ-004 Ports SHALL be, with clock and reset first:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- wrt_smpl  in  1  one-cycle strobe; a new stereo sample is present
- lft_smpl  in  16  signed left sample
- rght_smpl  in  16  signed right sample
- lft_out  out  16  signed left replay data to the FIR stages
- rght_out  out  16  signed right replay data to the FIR stages
- sequencing  out  1  high while lft_out/rght_out carry valid replay data

Function
REQ-005 Each wrt_smpl SHALL write {lft_smpl,rght_smpl} at new_ptr, then increment new_ptr modulo DEPTH.
REQ-006 The block SHALL count stored samples, saturating at WINDOW; the queue is full when count==WINDOW.
REQ-007 Before the queue is full, a write SHALL NOT start a readout, and sequencing SHALL stay 0.
REQ-008 Once the queue is full, each write SHALL start a readout, provided no readout is active.
REQ-009 A readout SHALL issue WINDOW consecutive read addresses, old_ptr .. old_ptr+WINDOW-1, each modulo DEPTH, one per cycle.
REQ-010 Read latency SHALL be 1 cycle. sequencing SHALL be high exactly on the WINDOW cycles that lft_out/rght_out carry read data: the oldest sample first, the newest last.
REQ-011 When a readout completes, old_ptr SHALL increment by 1 modulo DEPTH, so the window slides by one sample per write.
REQ-012 The FSM SHALL have the states:
- IDLE -> READ when a readout starts.
- READ -> DRAIN after the last address is issued.
- DRAIN -> IDLE after one cycle, with sequencing falling on the cycle after the last valid data.
REQ-013 A wrt_smpl during READ or DRAIN SHALL be written to memory. Its write location is outside the active window, so it cannot corrupt the replay.
REQ-014 That write SHALL also set a pending flag. The block SHALL enter READ on the first cycle after DRAIN, and the flag SHALL clear when READ is entered.
REQ-015 Multiple writes during one readout SHALL collapse into a single pending readout.
REQ-016 A wrt_smpl in the same cycle as the transition into IDLE SHALL be handled as in REQ-008.
REQ-017 All pointers SHALL wrap from DEPTH-1 to 0 without skipping or repeating an address.
REQ-018 Outside sequencing, lft_out/rght_out SHALL hold their last value. Downstream stages SHALL use the data only when sequencing is high.

Reset
REQ-019 On rst_n low, the following SHALL clear:
- new_ptr=0, old_ptr=0, read address=0
- count=0, pending=0
- state=IDLE, sequencing=0
REQ-020 lft_out/rght_out SHALL read 16'h0000 from reset until the first readout.
REQ-021 Reset during READ SHALL abort the readout immediately. The queue SHALL then refill WINDOW samples before the next readout.
REQ-022 Memory contents SHALL NOT require reset.

Structure
REQ-023 The DEPTH/WINDOW defaults and the state enum {IDLE,READ,DRAIN} SHALL live in shared package eq_pkg, alongside the FIR stage types.
REQ-024 Storage SHALL be one sub-module, dualPort1024x32:
- one synchronous write port
- one synchronous read port
- left channel in [31:16], right channel in [15:0]

Verification
REQ-025 Bench: write samples 1..1020 -> sequencing never asserts.
REQ-026 Bench: 1021st write (value 1021) -> within 2 cycles sequencing goes high for exactly 1021 cycles, and lft_out reads 1,2,...,1021 in order.
REQ-027 Bench: next write (value 1022) -> replay reads 2..1022, the window having slid by one.
REQ-028 Bench: 1030 writes total -> replay spans the pointer wrap with no gap or duplicate; the last replay reads 10..1030.
REQ-029 Bench: two wrt_smpl pulses during one readout -> exactly one extra readout follows back-to-back, starting with the oldest sample one higher.
REQ-030 Bench: assert rst_n mid-READ -> sequencing drops at once, outputs read 0, and no readout occurs until 1021 new writes.
